// File: rtl/ir_pkg.sv
// Shared definitions for the NEC IR transmit scheduler.
//   state_t               : scheduler FSM states
//   NEC_FRAME_CYCLES_50M  : 108 ms NEC start-to-start period in 50 MHz cycles
//   NEC_ADDR_W/NEC_CMD_W  : NEC address and command widths
//   FRAME_CNT_W           : width of the frame-period counter
//   clog2()               : index width helper, never returns less than 1
package ir_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT_ACK,
    WAIT_DONE,
    GAP
  } state_t;

  localparam int NEC_FRAME_CYCLES_50M = 5_400_000;
  localparam int NEC_ADDR_W           = 8;
  localparam int NEC_CMD_W            = 8;
  localparam int FRAME_CNT_W          = 23;

  function automatic int clog2(input int value);
    int width;
    width = 1;
    while ((1 << width) < value) width++;
    return width;
  endfunction

endpackage

// File: rtl/ir_tx_scheduler_rr_arbiter.sv
// Combinational round-robin picker.
//   req      : request vector
//   last     : index of the previous winner; search starts at last+1 with wrap
//   pick     : one-hot winner (all zero when nothing requests)
//   pick_idx : binary index of the winner
//   any_req  : at least one request is present
// The priority pointer itself is owned by the instantiating module.
module rr_arbiter
  import ir_pkg::*;
#(
  parameter int N = 4
) (
  input  logic [N-1:0]          req,
  input  logic [clog2(N)-1:0]   last,
  output logic [N-1:0]          pick,
  output logic [clog2(N)-1:0]   pick_idx,
  output logic                  any_req
);

  localparam int IW = clog2(N);

  // cand[gi] is the requester examined at search position gi (gi=0 first).
  logic [IW-1:0] cand [N];

  for (genvar gi = 0; gi < N; gi++) begin : g_cand
    logic [IW:0] sum;
    assign sum      = {1'b0, last} + (IW+1)'(gi + 1);
    assign cand[gi] = (sum >= (IW+1)'(N)) ? IW'(sum - (IW+1)'(N)) : sum[IW-1:0];
  end

  // Walk from the lowest-priority position down so the earliest hit wins.
  always_comb begin
    pick_idx = '0;
    any_req  = 1'b0;
    for (int k = N - 1; k >= 0; k--) begin
      if (req[cand[k]]) begin
        pick_idx = cand[k];
        any_req  = 1'b1;
      end
    end
  end

  assign pick = any_req ? (N'(1) << pick_idx) : '0;

endmodule

// File: rtl/ir_tx_scheduler.sv
// Shares one NEC IR transmitter among N_REQ requesters.
//   clk, rst            : 50 MHz clock, synchronous active-high reset
//   req/req_hold        : per-requester request level / repeat-while-held
//   req_addr/req_cmd    : packed 8-bit NEC address/command per requester
//   gnt                 : one-hot pulse on the cycle a full frame launches
//   tx_send/tx_repeat   : launch strobe and repeat-code flag to the transmitter
//   tx_addr/tx_cmd      : frame contents, stable from launch to next launch
//   tx_busy             : transmitter busy handshake
//   busy                : scheduler not idle
//   owner               : last granted requester (round-robin pointer)
//   err_timeout         : pulse when tx_busy never acknowledged a launch
module ir_tx_scheduler
  import ir_pkg::*;
#(
  parameter int N_REQ        = 4,
  parameter int FRAME_CYCLES = NEC_FRAME_CYCLES_50M,
  parameter int ACK_TIMEOUT  = 64,
  parameter int MAX_RPT      = 32
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [N_REQ-1:0]            req,
  input  logic [N_REQ-1:0]            req_hold,
  input  logic [NEC_ADDR_W*N_REQ-1:0] req_addr,
  input  logic [NEC_CMD_W*N_REQ-1:0]  req_cmd,
  output logic [N_REQ-1:0]            gnt,
  output logic                        tx_send,
  output logic                        tx_repeat,
  output logic [NEC_ADDR_W-1:0]       tx_addr,
  output logic [NEC_CMD_W-1:0]        tx_cmd,
  input  logic                        tx_busy,
  output logic                        busy,
  output logic [clog2(N_REQ)-1:0]     owner,
  output logic                        err_timeout
);

  localparam int IW = clog2(N_REQ);
  localparam int RW = clog2(MAX_RPT + 1);
  localparam logic [FRAME_CNT_W-1:0] FC_LAST  = FRAME_CNT_W'(FRAME_CYCLES - 1);
  localparam logic [FRAME_CNT_W-1:0] ACK_LAST = FRAME_CNT_W'(ACK_TIMEOUT - 1);

  state_t                 state_reg;
  logic [FRAME_CNT_W-1:0] frame_cnt_reg;
  logic [RW-1:0]          rpt_cnt_reg;
  logic                   hold_reg;

  logic [N_REQ-1:0] arb_pick;
  logic [IW-1:0]    arb_idx;
  logic             arb_any;

  rr_arbiter #(.N(N_REQ)) u_arb (
    .req      (req),
    .last     (owner),
    .pick     (arb_pick),
    .pick_idx (arb_idx),
    .any_req  (arb_any)
  );

  // The frame counter reads 0 on the tx_send cycle, so reaching FC_LAST with
  // the transmitter idle means the next launch lands exactly FRAME_CYCLES on.
  logic frame_done;
  logic decide;
  logic rpt_ok;
  logic launch_new;
  logic launch_rpt;

  assign frame_done = (frame_cnt_reg >= FC_LAST) && !tx_busy;
  // WAIT_DONE decides directly when busy drops after the period has elapsed,
  // so an overlong transmission is followed by a launch one cycle later.
  assign decide     = ((state_reg == GAP) || (state_reg == WAIT_DONE)) && frame_done;
  assign rpt_ok     = req[owner] && req_hold[owner] && hold_reg &&
                      (rpt_cnt_reg < RW'(MAX_RPT));
  assign launch_rpt = decide && rpt_ok;
  assign launch_new = arb_any &&
                      (((state_reg == IDLE) && !tx_busy) || (decide && !rpt_ok));

  assign busy = (state_reg != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      frame_cnt_reg <= '0;
      rpt_cnt_reg   <= '0;
      hold_reg      <= 1'b0;
      gnt           <= '0;
      tx_send       <= 1'b0;
      tx_repeat     <= 1'b0;
      tx_addr       <= '0;
      tx_cmd        <= '0;
      owner         <= IW'(N_REQ - 1);
      err_timeout   <= 1'b0;
    end else begin
      gnt         <= '0;
      tx_send     <= 1'b0;
      err_timeout <= 1'b0;
      if (frame_cnt_reg != FC_LAST) frame_cnt_reg <= frame_cnt_reg + 1'b1;

      if (launch_new) begin
        state_reg     <= ISSUE;
        frame_cnt_reg <= '0;
        rpt_cnt_reg   <= '0;
        hold_reg      <= req_hold[arb_idx];
        gnt           <= arb_pick;
        tx_send       <= 1'b1;
        tx_repeat     <= 1'b0;
        tx_addr       <= req_addr[int'(arb_idx)*NEC_ADDR_W +: NEC_ADDR_W];
        tx_cmd        <= req_cmd[int'(arb_idx)*NEC_CMD_W +: NEC_CMD_W];
        owner         <= arb_idx;
      end else if (launch_rpt) begin
        // Repeat code: same owner and payload, no grant pulse.
        state_reg     <= ISSUE;
        frame_cnt_reg <= '0;
        rpt_cnt_reg   <= rpt_cnt_reg + 1'b1;
        tx_send       <= 1'b1;
        tx_repeat     <= 1'b1;
      end else begin
        case (state_reg)
          ISSUE:     state_reg <= WAIT_ACK;
          WAIT_ACK: begin
            if (tx_busy) begin
              state_reg <= WAIT_DONE;
            end else if (frame_cnt_reg >= ACK_LAST) begin
              err_timeout <= 1'b1;
              state_reg   <= GAP;
            end
          end
          WAIT_DONE: if (!tx_busy) state_reg <= frame_done ? IDLE : GAP;
          GAP:       if (frame_done) state_reg <= IDLE;
          default:   state_reg <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ir_tx_scheduler.sv
module tb_ir_tx_scheduler;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  req = '0;
  logic [3:0]  req_hold = '0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_cmd = '0;
  logic [3:0]  gnt;
  logic        tx_send;
  logic        tx_repeat;
  logic [7:0]  tx_addr;
  logic [7:0]  tx_cmd;
  logic        tx_busy;
  logic        busy;
  logic [1:0]  owner;
  logic        err_timeout;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  ir_tx_scheduler #(
    .N_REQ        (4),
    .FRAME_CYCLES (200),
    .ACK_TIMEOUT  (8),
    .MAX_RPT      (3)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req         (req),
    .req_hold    (req_hold),
    .req_addr    (req_addr),
    .req_cmd     (req_cmd),
    .gnt         (gnt),
    .tx_send     (tx_send),
    .tx_repeat   (tx_repeat),
    .tx_addr     (tx_addr),
    .tx_cmd      (tx_cmd),
    .tx_busy     (tx_busy),
    .busy        (busy),
    .owner       (owner),
    .err_timeout (err_timeout)
  );

  // Transmitter model: busy rises 2 cycles after tx_send, lasts busy_len cycles.
  // It is deliberately not tied to rst so a frame survives a scheduler reset.
  logic mdl_clr  = 1'b1;
  bit   ack_en   = 1'b1;
  int   busy_len = 150;
  logic send_d;
  int   busy_left;

  always @(posedge clk) begin
    if (mdl_clr) begin
      send_d    <= 1'b0;
      tx_busy   <= 1'b0;
      busy_left <= 0;
    end else begin
      send_d <= tx_send;
      if (send_d && ack_en) begin
        tx_busy   <= 1'b1;
        busy_left <= busy_len;
      end else if (tx_busy) begin
        if (busy_left <= 1) tx_busy <= 1'b0;
        else busy_left <= busy_left - 1;
      end
    end
  end

  // Transaction log, sampled mid-cycle.
  int         q_send[$];
  bit         q_rpt[$];
  logic [3:0] q_gnt[$];
  logic [7:0] q_addr[$];
  logic [7:0] q_cmd[$];
  int         q_err[$];
  int         fall_cyc = 0;
  logic       busy_prev = 1'b0;

  always @(negedge clk) begin
    if (tx_send === 1'b1) begin
      q_send.push_back(cyc);
      q_rpt.push_back(tx_repeat);
      q_gnt.push_back(gnt);
      q_addr.push_back(tx_addr);
      q_cmd.push_back(tx_cmd);
      $display("send cyc=%0d repeat=%0b gnt=%b addr=%h cmd=%h owner=%0d",
               cyc, tx_repeat, gnt, tx_addr, tx_cmd, owner);
    end
    if (err_timeout === 1'b1) begin
      q_err.push_back(cyc);
      $display("timeout cyc=%0d", cyc);
    end
    if (busy_prev === 1'b1 && tx_busy === 1'b0) fall_cyc <= cyc;
    busy_prev <= tx_busy;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic clear_logs();
    q_send.delete();
    q_rpt.delete();
    q_gnt.delete();
    q_addr.delete();
    q_cmd.delete();
    q_err.delete();
  endtask

  task automatic do_reset();
    rst     = 1'b1;
    mdl_clr = 1'b1;
    repeat (3) @(negedge clk);
    rst     = 1'b0;
    mdl_clr = 1'b0;
    clear_logs();
  endtask

  task automatic wait_send(input string tag, output int t);
    t = -1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (tx_send === 1'b1) begin
        t = cyc;
        break;
      end
    end
    chk(tag, (t >= 0) ? 32'd1 : 32'd0, 32'd1);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_gnt"}, gnt, 0);
    chk({tag, "_send"}, tx_send, 0);
    chk({tag, "_rpt"}, tx_repeat, 0);
    chk({tag, "_addr"}, tx_addr, 0);
    chk({tag, "_cmd"}, tx_cmd, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_err"}, err_timeout, 0);
    chk({tag, "_owner"}, owner, 3);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0;
    int c;

    // Reset state
    do_reset();
    chk_reset_vals("rst");

    // 1: single request from requester 2
    req_addr[23:16] = 8'h5A;
    req_cmd[23:16]  = 8'h11;
    c   = cyc;
    req = 4'b0100;
    wait_send("t1_launch", t0);
    chk("t1_latency", t0 - c, 1);
    req = '0;
    repeat (199) @(negedge clk);
    chk("t1_busy_199", busy, 1);
    @(negedge clk);
    chk("t1_busy_200", busy, 0);
    repeat (20) @(negedge clk);
    chk("t1_sends", q_send.size(), 1);
    chk("t1_gnt", q_gnt[0], 4'b0100);
    chk("t1_rpt", q_rpt[0], 0);
    chk("t1_addr", q_addr[0], 8'h5A);
    chk("t1_cmd", q_cmd[0], 8'h11);
    chk("t1_owner", owner, 2);

    // 2: round robin over 0,1,3 held from reset
    req_addr = 32'h13121110;
    req_cmd  = 32'h23222120;
    req      = 4'b1011;
    do_reset();
    wait_send("t2_launch", t0);
    repeat (610) @(negedge clk);
    req = '0;
    chk("t2_sends", q_send.size(), 4);
    chk("t2_gnt0", q_gnt[0], 4'b0001);
    chk("t2_gnt1", q_gnt[1], 4'b0010);
    chk("t2_gnt2", q_gnt[2], 4'b1000);
    chk("t2_gnt3", q_gnt[3], 4'b0001);
    for (int i = 0; i < 3; i++) chk($sformatf("t2_space%0d", i), q_send[i+1] - q_send[i], 200);
    chk("t2_addr2", q_addr[2], 8'h13);
    chk("t2_cmd1", q_cmd[1], 8'h21);
    repeat (250) @(negedge clk);
    chk("t2_idle", busy, 0);

    // 3: held button gives 3 repeats then a fresh full frame
    req_addr[15:8] = 8'h77;
    req_cmd[15:8]  = 8'h88;
    do_reset();
    req      = 4'b0010;
    req_hold = 4'b0010;
    wait_send("t3_launch", t0);
    repeat (810) @(negedge clk);
    req      = '0;
    req_hold = '0;
    chk("t3_sends", q_send.size(), 5);
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("t3_rpt%0d", i), q_rpt[i], (i >= 1 && i <= 3) ? 1 : 0);
      chk($sformatf("t3_gnt%0d", i), q_gnt[i], (i >= 1 && i <= 3) ? 4'b0000 : 4'b0010);
    end
    for (int i = 0; i < 4; i++) chk($sformatf("t3_space%0d", i), q_send[i+1] - q_send[i], 200);
    chk("t3_rpt_addr", q_addr[3], 8'h77);
    chk("t3_rpt_cmd", q_cmd[3], 8'h88);
    repeat (300) @(negedge clk);

    // 4: transmitter never acknowledges
    ack_en = 1'b0;
    do_reset();
    req = 4'b0001;
    wait_send("t4_launch", t0);
    repeat (210) @(negedge clk);
    req = '0;
    chk("t4_sends", q_send.size(), 2);
    chk("t4_space", q_send[1] - q_send[0], 200);
    chk("t4_errs", q_err.size(), 2);
    chk("t4_err0", q_err[0] - q_send[0], 8);
    chk("t4_err1", q_err[1] - q_send[1], 8);
    repeat (250) @(negedge clk);
    ack_en = 1'b1;

    // 5: transmission outlasts the frame period
    busy_len = 300;
    do_reset();
    req = 4'b0001;
    wait_send("t5_launch", t0);
    repeat (310) @(negedge clk);
    req = '0;
    chk("t5_sends", q_send.size(), 2);
    chk("t5_space", q_send[1] - q_send[0], 303);
    chk("t5_after_fall", q_send[1] - fall_cyc, 1);
    repeat (400) @(negedge clk);
    busy_len = 150;

    // 6: reset while the transmitter is busy
    req_addr[7:0] = 8'h3C;
    req_cmd[7:0]  = 8'hC3;
    do_reset();
    req = 4'b0001;
    wait_send("t6_launch", t0);
    req = '0;
    repeat (49) @(negedge clk);
    chk("t6_pre_busy", busy, 1);
    rst = 1'b1;
    @(negedge clk);
    chk_reset_vals("t6_rst");
    rst = 1'b0;
    clear_logs();
    req = 4'b0001;
    repeat (150) @(negedge clk);
    req = '0;
    chk("t6_sends", q_send.size(), 1);
    chk("t6_after_fall", q_send[0] - fall_cyc, 1);
    chk("t6_gnt", q_gnt[0], 4'b0001);
    chk("t6_addr", q_addr[0], 8'h3C);
    repeat (250) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
